ddr_req_arbiter: RTL and testbench
==================================

// Module: ddr_req_arbiter
// PURPOSE
// - Initiator side of the ddr_* word-memory handshake. Arbitrates the core's instruction-fetch (if_*) and data (mem_*)
//   ports onto a single ddr_* master, holds each request stable until ddr_resp, and routes the response back.
// - Sits between the rvga pipeline and the DDR memory model/controller. Adds a bus timeout watchdog.
// PARAMETERS
// - TIMEOUT_CYCLES  1024        BUSY cycles without ddr_resp before abort; must be >= 2
// - TIMEOUT_DATA    32'hDEAD_BEEF  rdata returned to the client on an aborted transfer
// PORTS
// - clk          in   1   clock
// - rst_n        in   1   asynchronous active-low reset
// - if_addr      in   32  fetch address (rvga_word)
// - if_read      in   1   fetch request; held high until if_resp
// - if_rdata     out  32  fetch data, valid while if_resp=1
// - if_resp      out  1   one-cycle fetch completion pulse
// - mem_addr     in   32  data address
// - mem_read     in   1   data read request; held until mem_resp
// - mem_write    in   1   data write request; held until mem_resp
// - mem_wdata    in   32  write data
// - mem_rdata    out  32  read data, valid while mem_resp=1
// - mem_resp     out  1   one-cycle data completion pulse
// - ddr_addr     out  32  word address to memory (bits[1:0] forced 0)
// - ddr_read     out  1   read request
// - ddr_write    out  1   write request
// - ddr_wdata    out  32  write data
// - ddr_rdata    in   32  read data, valid with ddr_resp
// - ddr_resp     in   1   one-cycle completion pulse from memory
// - timeout_err  out  1   sticky: a transfer was aborted by the watchdog
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; ddr_read/ddr_write/ddr_addr/ddr_wdata=0; if_resp/mem_resp=0;
//   rdata outs=0; timeout_err=0; wdog=0; last_grant=DATA (first tie goes to IF). Reset mid-transfer drops
//   the request immediately; no response is ever issued for it.
// - FSM: IDLE -> BUSY -> GAP -> IDLE.
//   IDLE: if any request, grant, latch addr(&~3)/wdata/op into registers, go BUSY; ddr_* driven from registers next cycle.
//   BUSY: ddr_read xor ddr_write held, addr/wdata stable. On ddr_resp: pulse granted client's resp for exactly that
//     cycle (combinational: resp=ddr_resp & grant, rdata=ddr_rdata), deassert ddr_read/write at next edge, go GAP.
//   GAP: one cycle, all ddr requests low (memory needs an idle cycle to return to its idle state), no new grant, go IDLE.
// - Latency: request seen in IDLE at edge N -> ddr_* valid after edge N; client resp same cycle as ddr_resp.
//   Minimum 3 cycles per transfer (zero-latency memory); back-to-back requests: one every 3 cycles min.
// - Arbitration: round-robin between IF and DATA; on tie, grant the port not granted last; single requester always wins.
//   last_grant updated on every grant.
// - mem_read & mem_write both high: treated as write (read ignored).
// - Client must hold its request through its resp; a request that drops while not granted is simply not served;
//   a request that drops while granted does not abort the ddr transfer (completes, resp still pulsed).
// - Non-granted client's resp stays 0; its rdata out holds 0 whenever its resp=0.
// - Watchdog: wdog counts BUSY cycles, clears on leaving BUSY. At wdog==TIMEOUT_CYCLES-1 with no ddr_resp:
//   set timeout_err (sticky until reset), pulse client resp with rdata=TIMEOUT_DATA (writes: resp only),
//   drop ddr request, go GAP. ddr_resp in same cycle as expiry wins (normal completion, no error).
// - ddr_resp seen in IDLE or GAP: ignored, no client response.
// STRUCTURE
// - Shared package (rvga_types/rvga_params): rvga_word, ddr_arb_state_t {IDLE,BUSY,GAP}, ddr_port_t {PORT_IF,PORT_DATA},
//   DDR_TIMEOUT_DATA default constant.
// - One sub-module: rr_arb2 (2-input round-robin arbiter: req[1:0], advance, -> grant one-hot, last_grant reg).
// - Top holds FSM, request registers, watchdog counter, response routing.
// TESTING (bench uses the word-memory model with latency parameter 0 and 5)
// - Reset: rst_n low mid-BUSY -> ddr_read/ddr_write=0 asynchronously, no if_resp/mem_resp, timeout_err=0.
// - Fetch only: if_read, if_addr=32'h0000_0013 -> ddr_addr=32'h10, ddr_read=1; if_resp one cycle with word at 0x10.
// - Write then read: mem_write addr 0x40 wdata 32'hCAFE_F00D, then mem_read 0x40 -> mem_rdata=32'hCAFE_F00D;
//   ddr_read/write low for exactly one cycle between transfers.
// - Contention: if_read and mem_read asserted same cycle, held 4 transfers -> grants IF,DATA,IF,DATA; no resp crosses ports.
// - Timeout: memory never responds, TIMEOUT_CYCLES=8 -> client resp at 8th BUSY cycle, rdata=32'hDEAD_BEEF,
//   timeout_err=1 and stays 1 across later successful transfers.
// - Edge: mem_read and mem_write both high -> ddr_write=1 only; ddr_resp injected in IDLE -> no client resp.

Source files
------------

// File: rtl/ddr_req_arbiter_pkg.sv
// Shared types and defaults for the ddr_* request arbiter.
// Word type, FSM states, client port ids and the default abort read data.
package ddr_req_arbiter_pkg;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } ddr_arb_state_t;

    typedef enum logic {
        PORT_IF   = 1'b0,
        PORT_DATA = 1'b1
    } ddr_port_t;

    localparam rvga_word    DDR_TIMEOUT_DATA   = 32'hDEAD_BEEF;
    localparam int unsigned DDR_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ddr_req_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: bit 0 is the fetch port, bit 1 the data port.
// On a tie the port that did not win last time is granted.
module rr_arb2
    import ddr_req_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output ddr_port_t  last_grant_o
);

    ddr_port_t last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && (|req_i)) begin
            last_d = grant_o[1] ? PORT_DATA : PORT_IF;
        end
    end

    // Reset to DATA so that the very first tie goes to the fetch port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant_o = last_q;

endmodule

// File: rtl/ddr_req_arbiter.sv
// Arbitrates fetch and data clients onto one ddr_* word-memory master,
// holds each request until ddr_resp or watchdog expiry, and routes the response back.
//   state | meaning
//   IDLE  | no transfer; grant and latch a pending request
//   BUSY  | ddr request driven from registers, waiting for ddr_resp or timeout
//   GAP   | one idle cycle with all ddr requests low before the next grant
module ddr_req_arbiter
    import ddr_req_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DDR_TIMEOUT_CYCLES,
    parameter rvga_word    TIMEOUT_DATA   = DDR_TIMEOUT_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_addr,
    input  logic        if_read,
    output logic [31:0] if_rdata,
    output logic        if_resp,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic [31:0] ddr_addr,
    output logic        ddr_read,
    output logic        ddr_write,
    output logic [31:0] ddr_wdata,
    input  logic [31:0] ddr_rdata,
    input  logic        ddr_resp,
    output logic        timeout_err
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    ddr_arb_state_t    state_q, state_d;
    ddr_port_t         port_q, port_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    rvga_word          addr_q, addr_d;
    rvga_word          wdata_q, wdata_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              terr_q, terr_d;

    logic [1:0] req;
    logic [1:0] grant;
    ddr_port_t  last_grant;
    logic       expire;
    logic       xfer_done;
    rvga_word   rsp_data;

    assign req = {mem_read | mem_write, if_read};

    rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .advance_i    (state_q == IDLE),
        .grant_o      (grant),
        .last_grant_o (last_grant)
    );

    // A response arriving in the expiry cycle counts as a normal completion.
    assign expire    = (state_q == BUSY) && !ddr_resp && (wdog_q == WDOG_LAST);
    assign xfer_done = (state_q == BUSY) && (ddr_resp || expire);

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wdog_d  = '0;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    if (grant[1]) begin
                        port_d  = PORT_DATA;
                        addr_d  = mem_addr & ~32'h3;
                        wdata_d = mem_wdata;
                        wr_d    = mem_write;
                        rd_d    = mem_read & ~mem_write;
                    end else begin
                        port_d  = PORT_IF;
                        addr_d  = if_addr & ~32'h3;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (xfer_done) begin
                    state_d = GAP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    terr_d  = terr_q | expire;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= PORT_IF;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    // Aborted reads return the poison word; aborted writes carry no data.
    assign rsp_data = ddr_resp ? ddr_rdata : (rd_q ? TIMEOUT_DATA : '0);

    assign if_resp   = xfer_done && (port_q == PORT_IF);
    assign mem_resp  = xfer_done && (port_q == PORT_DATA);
    assign if_rdata  = if_resp  ? rsp_data : '0;
    assign mem_rdata = mem_resp ? rsp_data : '0;

    assign ddr_addr    = addr_q;
    assign ddr_read    = rd_q;
    assign ddr_write   = wr_q;
    assign ddr_wdata   = wdata_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter with a word-memory model of adjustable latency
// and a scoreboard of expected client responses.
module tb_ddr_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic        if_read, mem_read, mem_write;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_resp, mem_resp;
    logic [31:0] ddr_addr, ddr_wdata, ddr_rdata;
    logic        ddr_read, ddr_write, ddr_resp;
    logic        timeout_err;

    always #5 clk = ~clk;

    ddr_req_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_read(if_read), .if_rdata(if_rdata), .if_resp(if_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .ddr_addr(ddr_addr), .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_wdata(ddr_wdata),
        .ddr_rdata(ddr_rdata), .ddr_resp(ddr_resp), .timeout_err(timeout_err)
    );

    // word memory model: responds after `lat` request cycles; unwritten words read 0xA500_0000|addr
    int       lat = 0;
    bit       mem_en = 1'b1;
    logic     inj = 1'b0;
    int       mcnt = 0;
    bit [31:0] mem_arr [256];
    bit        mem_vld [256];
    logic      model_resp;

    assign model_resp = mem_en && (ddr_read || ddr_write) && (mcnt == lat);
    assign ddr_resp   = model_resp | inj;
    assign ddr_rdata  = !ddr_resp ? 32'h0 :
                        (mem_vld[ddr_addr[9:2]] ? mem_arr[ddr_addr[9:2]] : (32'hA500_0000 | ddr_addr));

    always @(posedge clk) begin
        if (ddr_read || ddr_write) begin
            if (model_resp) begin
                mcnt <= 0;
                if (ddr_write) begin
                    mem_arr[ddr_addr[9:2]] <= ddr_wdata;
                    mem_vld[ddr_addr[9:2]] <= 1'b1;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_data;
        bit          chk_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t q_exp[$];
    exp_t mon_e;
    int   nresp = 0;
    int   resp_cyc[$];

    always @(negedge clk) begin
        if (if_resp || mem_resp) begin
            resp_cyc.push_back(cyc_n);
            if (q_exp.size() == 0) begin
                chk("unexpected_resp", {30'd0, if_resp, mem_resp}, 32'd0);
            end else begin
                mon_e = q_exp.pop_front();
                if (mon_e.is_data) begin
                    chk("resp_port_data", {30'd0, if_resp, mem_resp}, 32'd1);
                    chk("if_rdata_quiet", if_rdata, 32'd0);
                    if (mon_e.chk_data) chk("mem_rdata", mem_rdata, mon_e.rdata);
                end else begin
                    chk("resp_port_if", {30'd0, if_resp, mem_resp}, 32'd2);
                    chk("mem_rdata_quiet", mem_rdata, 32'd0);
                    if (mon_e.chk_data) chk("if_rdata", if_rdata, mon_e.rdata);
                end
            end
            nresp++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resps(input int target, input int budget);
        int c = 0;
        while (nresp < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("resp_wait", {31'd0, nresp >= target}, 32'd1);
    endtask

    task automatic push(input bit is_data, input bit chk_data, input logic [31:0] rdata);
        exp_t e;
        e.is_data  = is_data;
        e.chk_data = chk_data;
        e.rdata    = rdata;
        q_exp.push_back(e);
    endtask

    initial begin
        int exp_n = 0;
        int base;
        rst_n = 1'b0;
        if_addr = '0; if_read = 1'b0;
        mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
        cyc(3);
        chk("rst_ddr_read", {31'd0, ddr_read}, 32'd0);
        chk("rst_ddr_write", {31'd0, ddr_write}, 32'd0);
        chk("rst_ddr_addr", ddr_addr, 32'd0);
        chk("rst_resp", {30'd0, if_resp, mem_resp}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // single fetch, zero-latency memory
        lat = 0;
        if_addr = 32'h0000_0013; if_read = 1'b1;
        push(1'b0, 1'b1, 32'hA500_0010); exp_n++;
        cyc(1);
        chk("fetch_ddr_addr", ddr_addr, 32'h10);
        chk("fetch_ddr_read", {31'd0, ddr_read}, 32'd1);
        chk("fetch_ddr_write", {31'd0, ddr_write}, 32'd0);
        wait_resps(exp_n, 20);
        if_read = 1'b0;
        cyc(2);

        // write then read back, latency 5
        lat = 5;
        mem_addr = 32'h40; mem_wdata = 32'hCAFE_F00D; mem_write = 1'b1;
        push(1'b1, 1'b0, 32'h0); exp_n++;
        cyc(1);
        chk("wr_ddr_write", {31'd0, ddr_write}, 32'd1);
        chk("wr_ddr_wdata", ddr_wdata, 32'hCAFE_F00D);
        wait_resps(exp_n, 40);
        mem_write = 1'b0;
        chk("gap_ddr_req", {30'd0, ddr_read, ddr_write}, 32'd0);
        mem_read = 1'b1;
        push(1'b1, 1'b1, 32'hCAFE_F00D); exp_n++;
        wait_resps(exp_n, 40);
        mem_read = 1'b0;
        cyc(2);

        // contention: both held for four transfers
        lat = 0;
        if_addr = 32'h100; mem_addr = 32'h200;
        if_read = 1'b1; mem_read = 1'b1;
        base = resp_cyc.size();
        push(1'b0, 1'b1, 32'hA500_0100);
        push(1'b1, 1'b1, 32'hA500_0200);
        push(1'b0, 1'b1, 32'hA500_0100);
        push(1'b1, 1'b1, 32'hA500_0200);
        exp_n += 4;
        wait_resps(exp_n, 40);
        if_read = 1'b0; mem_read = 1'b0;
        if (resp_cyc.size() >= base + 4) begin
            for (int i = 1; i < 4; i++)
                chk("contention_cadence", resp_cyc[base+i] - resp_cyc[base+i-1], 32'd3);
        end else begin
            chk("contention_count", resp_cyc.size() - base, 32'd4);
        end
        cyc(2);

        // read and write together act as a write
        mem_addr = 32'h80; mem_wdata = 32'h1234_5678; mem_read = 1'b1; mem_write = 1'b1;
        push(1'b1, 1'b0, 32'h0); exp_n++;
        cyc(1);
        chk("rw_ddr_write", {31'd0, ddr_write}, 32'd1);
        chk("rw_ddr_read", {31'd0, ddr_read}, 32'd0);
        wait_resps(exp_n, 20);
        mem_read = 1'b0; mem_write = 1'b0;
        cyc(2);

        // stray ddr_resp while idle
        inj = 1'b1;
        #1;
        chk("idle_resp_ignored", {30'd0, if_resp, mem_resp}, 32'd0);
        cyc(1);
        inj = 1'b0;
        chk("idle_stays_idle", {30'd0, ddr_read, ddr_write}, 32'd0);
        cyc(1);

        // watchdog: memory silent, abort on the 8th BUSY cycle
        mem_en = 1'b0;
        if_addr = 32'h20; if_read = 1'b1;
        push(1'b0, 1'b1, 32'hDEAD_BEEF); exp_n++;
        cyc(1);
        cyc(6);
        chk("wdog_7th_quiet", {31'd0, if_resp}, 32'd0);
        cyc(1);
        chk("wdog_8th_resp", {31'd0, if_resp}, 32'd1);
        chk("wdog_rdata", if_rdata, 32'hDEAD_BEEF);
        wait_resps(exp_n, 10);
        chk("wdog_err_set", {31'd0, timeout_err}, 32'd1);
        chk("wdog_ddr_dropped", {31'd0, ddr_read}, 32'd0);
        if_read = 1'b0;
        mem_en = 1'b1;
        cyc(2);
        if_addr = 32'h24; if_read = 1'b1;
        push(1'b0, 1'b1, 32'hA500_0024); exp_n++;
        wait_resps(exp_n, 20);
        if_read = 1'b0;
        chk("wdog_err_sticky", {31'd0, timeout_err}, 32'd1);
        cyc(2);

        // reset in the middle of a transfer
        lat = 5;
        if_addr = 32'h30; if_read = 1'b1;
        cyc(2);
        chk("mid_busy_read", {31'd0, ddr_read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_read", {31'd0, ddr_read}, 32'd0);
        chk("rst_async_resp", {30'd0, if_resp, mem_resp}, 32'd0);
        if_read = 1'b0;
        cyc(2);
        chk("rst_err_clear", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        cyc(10);
        chk("resp_total", nresp, exp_n);
        chk("scoreboard_empty", q_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
